// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the execute-stage controller and the iterative
// multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes, with the
// sign fixed up in a final cycle before HI/LO are written.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic [WIDTH-1:0]   raw_a_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic [WIDTH-1:0]   upper_reg, upper_next;
    logic [WIDTH-1:0]   lower_reg, lower_next;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               dbz_reg;

    logic               signed_op, sign_a, sign_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops work on magnitudes; the most negative value is its own magnitude.
    assign signed_op = ~bus.op[0];
    assign sign_a    = signed_op & bus.operand_a[WIDTH-1];
    assign sign_b    = signed_op & bus.operand_b[WIDTH-1];
    assign abs_a     = sign_a ? -bus.operand_a : bus.operand_a;
    assign abs_b     = sign_b ? -bus.operand_b : bus.operand_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.start) state_next = S_CALC;
            S_CALC: if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shift-add multiply keeps the product in {upper, lower}, consuming the
    // multiplier from lower's LSB; restoring divide shifts the dividend out of
    // lower's MSB into the partial remainder in upper.
    always_comb begin
        mul_sum   = {1'b0, upper_reg} + {1'b0, (lower_reg[0] ? operand_reg : '0)};
        div_shift = {upper_reg, lower_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_reg};
        if (is_div_reg) begin
            upper_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lower_next = {lower_reg[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            upper_next = mul_sum[WIDTH:1];
            lower_next = {mul_sum[0], lower_reg[WIDTH-1:1]};
        end
        prod_fix = neg_q_reg ? -{upper_reg, lower_reg} : {upper_reg, lower_reg};
        quo_fix  = neg_q_reg ? -lower_reg : lower_reg;
        rem_fix  = neg_r_reg ? -upper_reg : upper_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            raw_a_reg   <= '0;
            operand_reg <= '0;
            upper_reg   <= '0;
            lower_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div_reg  <= bus.op[1];
                        neg_q_reg   <= sign_a ^ sign_b;
                        neg_r_reg   <= sign_a;
                        raw_a_reg   <= bus.operand_a;
                        cnt_reg     <= '0;
                        dbz_reg     <= 1'b0;
                        upper_reg   <= '0;
                        lower_reg   <= bus.op[1] ? abs_a : abs_b;
                        operand_reg <= bus.op[1] ? abs_b : abs_a;
                    end else begin
                        if (bus.wr_hi) hi_reg <= bus.wdata;
                        if (bus.wr_lo) lo_reg <= bus.wdata;
                    end
                end
                S_CALC: begin
                    cnt_reg   <= cnt_reg + 1'b1;
                    upper_reg <= upper_next;
                    lower_reg <= lower_next;
                end
                S_FIX: begin
                    if (!is_div_reg) begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end else if (operand_reg == '0) begin
                        hi_reg  <= raw_a_reg;
                        lo_reg  <= '1;
                        dbz_reg <= 1'b1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.div_by_zero = dbz_reg;
    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against an arithmetic reference
// model built on native SV multiply, divide and modulo.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rd);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        rd = 1'b0;
        rh = '0;
        rl = '0;
        case (op)
            2'd0: begin p = longint'(sa) * longint'(sb); rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (b == 0) begin
                    rh = a; rl = '1; rd = 1'b1;
                end else if (op == 2'd3) begin
                    rl = a / b; rh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = '0;
                end else begin
                    rl = 32'(sa / sb); rh = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit wr_too, input string tag);
        logic [W-1:0] eh, el;
        logic ed;
        int n, bc;
        model(op, a, b, eh, el, ed);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
        if (wr_too) begin bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = ~m_hi; end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        bus.operand_a = $urandom; bus.operand_b = $urandom; bus.op = 2'($urandom);
        n = 0; bc = 0;
        while (1) begin
            if (bus.busy === 1'b1) bc++;
            if (n == 16) begin
                chk({tag, "_hold_hi"}, 64'(bus.hi), 64'(m_hi));
                chk({tag, "_hold_lo"}, 64'(bus.lo), 64'(m_lo));
            end
            if (bus.done === 1'b1 || n >= 100) break;
            @(posedge clk); n++; @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(n), 64'(W + 1));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(W + 2));
        chk({tag, "_hi"}, 64'(bus.hi), 64'(eh));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(el));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
        @(negedge clk);
        chk({tag, "_idle"}, {62'b0, bus.busy, bus.done}, 64'd0);
        m_hi = eh; m_lo = el;
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b done_after_edge=%0d",
                 tag, op, a, b, bus.hi, bus.lo, bus.div_by_zero, n);
    endtask

    initial begin
        int dones;
        logic [W-1:0] eh, el, ra, rb;
        logic ed;
        logic [1:0] rop;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {bus.hi, bus.lo}, 64'd0);
        chk("reset_flags", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        rst = 1'b0;
        $display("reset released");

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        do_op(2'd3, 32'h0000_1234, 32'd0, 1'b0, "divu_zero");
        do_op(2'd3, 32'd100, 32'd7, 1'b0, "divu_100_7");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(2'd1, 32'd0, 32'hDEAD_BEEF, 1'b0, "multu_zero");
        do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b1, "div_zero_neg");
        do_op(2'd2, 32'd0, 32'hFFFF_FFF3, 1'b1, "div_zero_num");

        // Start and MTHI while busy must both be ignored.
        model(2'd1, 32'd6, 32'd7, eh, el, ed);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            bus.start = (cyc == 10);
            if (cyc == 10) begin bus.op = 2'd3; bus.operand_a = 32'd1000; bus.operand_b = 32'd3; end
            bus.wr_hi = (cyc == 12);
            bus.wdata = 32'hDEAD_0001;
        end
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        chk("busy_ignore_dones", 64'(dones), 64'd1);
        chk("busy_ignore_hi", 64'(bus.hi), 64'(eh));
        chk("busy_ignore_lo", 64'(bus.lo), 64'(el));
        $display("busy_ignore: dones=%0d hi=%h lo=%h", dones, bus.hi, bus.lo);
        m_hi = eh; m_lo = el;

        bus.wr_lo = 1'b1; bus.wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        bus.wr_lo = 1'b0;
        m_lo = 32'h55;
        chk("mtlo_lo", 64'(bus.lo), 64'(m_lo));
        chk("mtlo_hi", 64'(bus.hi), 64'(m_hi));
        $display("mtlo: hi=%h lo=%h", bus.hi, bus.lo);

        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'hA5A5_5A5A;
        @(posedge clk);
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        m_hi = 32'hA5A5_5A5A; m_lo = 32'hA5A5_5A5A;
        chk("mthi_mtlo", {bus.hi, bus.lo}, {m_hi, m_lo});
        $display("mthi_mtlo: hi=%h lo=%h", bus.hi, bus.lo);

        // Asynchronous reset in the middle of a divide.
        bus.start = 1'b1; bus.op = 2'd2; bus.operand_a = 32'd999; bus.operand_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_regs", {bus.hi, bus.lo}, 64'd0);
        chk("mid_rst_flags", {61'b0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        dones = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        chk("post_rst_quiet", 64'(dones), 64'd0);
        $display("mid_op_reset: activity_after_release=%0d", dones);
        do_op(2'd2, 32'd999, 32'd4, 1'b0, "div_after_rst");

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 20));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            do_op(rop, ra, rb, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and produces a 64-bit result in internal HI/LO registers.
- Implements the MULT, MULTU, DIV and DIVU operations with a start/busy/done handshake.
- The controller stalls the pipeline while busy is high. MFHI/MFLO values are read from hi/lo and written back through the register file write port.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- operand_a  input  WIDTH  rs value: multiplicand or dividend.
- operand_b  input  WIDTH  rt value: multiplier or divisor.
- wr_hi  input  1  MTHI: write wdata to hi.
- wr_lo  input  1  MTLO: write wdata to lo.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high from the cycle after start is accepted until done drops.
- done  output  1  one-cycle pulse; hi/lo hold the new result from this cycle on.
- div_by_zero  output  1  valid with done; high when a DIV/DIVU had operand_b == 0.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset: async, takes effect immediately, also mid-operation.
  - State goes to IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - The in-flight operation is discarded and no partial result is written.
- States and transitions:
  - IDLE: on start=1, latch op and operands, go to CALC.
    - Signed ops latch absolute values plus result-sign flags.
    - Quotient sign = sign_a XOR sign_b; remainder sign = sign_a; product sign = sign_a XOR sign_b.
  - CALC: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
    - Multiply: shift-add, one multiplier bit per cycle.
    - Divide: restoring division, one quotient bit per cycle.
  - FIX: apply two's-complement sign correction, write hi/lo, go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency and handshake:
  - start is sampled at edge 0; done is high between edge WIDTH+1 and edge WIDTH+2.
  - busy=1 in CALC, FIX and DONE; a new start is accepted at the first edge after DONE.
  - start while busy is ignored; the operation is not queued.
  - Operands are captured at acceptance; later changes on operand_a/b have no effect.
- Divide by zero:
  - The operation still runs the full latency.
  - Result: hi = operand_a (raw, uncorrected), lo = all ones, div_by_zero=1 with done.
  - For multiplies, div_by_zero=0.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = 0x80000000, hi = 0; no flag raised.
- Zero operands: multiply by 0 gives hi=lo=0; 0 / x gives hi=lo=0.
- MTHI/MTLO:
  - Honoured only in IDLE with start=0; written at the next edge.
  - Ignored while busy, and ignored when start=1 in the same cycle (start has priority).
  - wr_hi and wr_lo may be asserted together.
- Output stability:
  - hi/lo change only in FIX, on MTHI/MTLO, or on reset.
  - During CALC they hold the previous values, so MFHI/MFLO reads stay stable.
- div_by_zero holds its value until the next accepted start clears it.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at edge 0 -> done pulses after edge 33 (WIDTH=32); hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 34 cycles.
- MULT -3 * 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
- DIVU 0x00001234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1 with done. Then DIVU 100 / 7 -> lo=14, hi=2, div_by_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Then MULTU 0 * 0xDEADBEEF -> hi=lo=0.
- Start MULTU 6*7, pulse start again with DIVU operands at cycle 10, assert wr_hi at cycle 12 -> only one done, hi=0, lo=42. A subsequent IDLE wr_lo with wdata=0x55 -> lo=0x55.
- Assert rst asynchronously at cycle 15 of a DIV, mid-clock -> busy/done/hi/lo drop to 0 immediately with no done pulse. A start after release -> normal full latency.
